// File: rtl/keyboard_decoder_pkg.sv
// Shared scan-code constants and decoder state type for the keyboard front end.
// Imported by keyboard_decoder and anything else that interprets PS/2 set-2 bytes.
package keyboard_decoder_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // Three bits leave room for E1/pause handling later.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BREAK     = 3'd1,
        ST_EXT       = 3'd2,
        ST_EXT_BREAK = 3'd3
    } kbd_state_t;

endpackage

// File: rtl/keyboard_decoder.sv
// Turns the PS/2 set-2 byte stream into registered key-held levels and a sticky
// start_game flag for the movement FSM; stalled prefixes are abandoned after a timeout.
module keyboard_decoder
    import keyboard_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 6_500_000,
    localparam int unsigned CNT_WIDTH     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    input  logic       game_over,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic       jump,
    output logic       start_game
);

    kbd_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 left_d, right_d, up_d, down_d, jump_d, start_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            left       <= 1'b0;
            right      <= 1'b0;
            up         <= 1'b0;
            down       <= 1'b0;
            jump       <= 1'b0;
            start_game <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            left       <= left_d;
            right      <= right_d;
            up         <= up_d;
            down       <= down_d;
            jump       <= jump_d;
            start_game <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left;
        right_d = right;
        up_d    = up;
        down_d  = down;
        jump_d  = jump;
        start_d = start_game;

        if (rx_error) begin
            // A corrupted byte could have been anything, so drop any partial sequence.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (rx_valid) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    case (rx_data)
                        SC_EXT:   state_d = ST_EXT;
                        SC_BREAK: state_d = ST_BREAK;
                        SC_SPACE: jump_d  = 1'b1;
                        SC_ENTER: start_d = 1'b1;
                        default: ;
                    endcase
                end
                ST_BREAK: begin
                    if (rx_data == SC_SPACE)
                        jump_d = 1'b0;
                end
                ST_EXT: begin
                    case (rx_data)
                        SC_BREAK: state_d = ST_EXT_BREAK;
                        SC_LEFT:  left_d  = 1'b1;
                        SC_RIGHT: right_d = 1'b1;
                        SC_UP:    up_d    = 1'b1;
                        SC_DOWN:  down_d  = 1'b1;
                        default: ;
                    endcase
                end
                ST_EXT_BREAK: begin
                    case (rx_data)
                        SC_LEFT:  left_d  = 1'b0;
                        SC_RIGHT: right_d = 1'b0;
                        SC_UP:    up_d    = 1'b0;
                        SC_DOWN:  down_d  = 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (game_over)
            start_d = 1'b0;
    end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Scoreboard bench for keyboard_decoder: stimulus updates a prefix-queue reference model
// and queues the expected outputs; a monitor pops one entry per clock and compares.
module tb_keyboard_decoder;

    localparam int unsigned T = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       game_over = 1'b0;
    logic       left, right, up, down, jump, start_game;

    keyboard_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .game_over(game_over), .left(left), .right(right),
        .up(up), .down(down), .jump(jump), .start_game(start_game)
    );

    always #5 clk = ~clk;

    // Reference model: pending prefix bytes, idle cycles since the last byte, key levels.
    logic [7:0] pend[$];
    int         idle_cnt = 0;
    bit         m_held[4];          // left, right, up, down
    bit         m_jump = 1'b0;
    bit         m_start = 1'b0;
    logic [5:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc_no = 0;

    function automatic int arrow_idx(input logic [7:0] b);
        case (b)
            8'h6B:   return 0;
            8'h74:   return 1;
            8'h75:   return 2;
            8'h72:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [5:0] model_outs();
        return {m_held[0], m_held[1], m_held[2], m_held[3], m_jump, m_start};
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int a;
        a = arrow_idx(b);
        if (pend.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
            else if (b == 8'h29) m_jump = 1'b1;
            else if (b == 8'h5A) m_start = 1'b1;
        end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
            if (b == 8'h29) m_jump = 1'b0;
            pend.delete();
        end else if (pend.size() == 1 && pend[0] == 8'hE0) begin
            if (b == 8'hF0) pend.push_back(b);
            else begin
                if (a >= 0) m_held[a] = 1'b1;
                pend.delete();
            end
        end else begin
            if (a >= 0) m_held[a] = 1'b0;
            pend.delete();
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit e,
                              input bit go, input bit r);
        if (r) begin
            pend.delete();
            idle_cnt = 0;
            for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
            m_jump  = 1'b0;
            m_start = 1'b0;
        end else begin
            if (e) begin
                pend.delete();
                idle_cnt = 0;
            end else if (v) begin
                idle_cnt = 0;
                model_byte(d);
            end else if (pend.size() > 0) begin
                idle_cnt++;
                if (idle_cnt >= int'(T)) begin
                    pend.delete();
                    idle_cnt = 0;
                end
            end
            if (go) m_start = 1'b0;
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit e,
                       input bit go, input bit r);
        @(negedge clk);
        rst       = r;
        rx_valid  = v;
        rx_data   = d;
        rx_error  = e;
        game_over = go;
        model_step(v, d, e, go, r);
        exp_q.push_back(model_outs());
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per clock, sampled just after the edge.
    initial begin
        logic [5:0] act, want;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                act  = {left, right, up, down, jump, start_game};
                total++;
                if (act !== want) begin
                    bad++;
                    $display("FAIL outs cycle=%0d got{l,r,u,d,j,s}=%b want=%b",
                             cyc_no, act, want);
                end
            end
        end
    end

    initial begin
        logic [7:0] pool[10];
        pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h5A, 8'hE1, 8'h00};
        for (int i = 0; i < 4; i++) m_held[i] = 1'b0;

        // Reset state
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Reset mid-sequence: the following 6B is a plain keypad code
        send(8'hE0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        send(8'h6B);
        idle(2);

        // Extended make/break
        send(8'hE0); send(8'h6B); idle(2);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(2);

        // Space typematic repeat then break
        send(8'h29); idle(3); send(8'h29); idle(3); send(8'h29); idle(2);
        send(8'hF0); send(8'h29); idle(2);

        // Keypad codes without E0
        send(8'h6B); send(8'h74); send(8'h75); send(8'h72); idle(2);

        // Timeout expires exactly, then just before expiry the byte wins
        send(8'hE0); idle(T); send(8'h74); idle(2);
        send(8'hE0); idle(T - 1); send(8'h74); idle(2);
        send(8'hE0); send(8'hF0); idle(T - 1); send(8'h74); idle(2);

        // rx_error aborts a prefix; byte with error is dropped
        send(8'h29); send(8'hE0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        send(8'hF0); send(8'h29); idle(2);
        cyc(1'b1, 8'h29, 1'b1, 1'b0, 1'b0); idle(2);

        // start_game sticky, game_over priority
        send(8'h5A); idle(1);
        send(8'hF0); send(8'h5A); idle(2);
        cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0); idle(2);
        send(8'h5A); cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); idle(1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit v, e, go, r;
            logic [7:0] d;
            if ($urandom_range(0, 99) < 3) begin
                idle($urandom_range(T - 3, T + 3));
            end else begin
                v  = ($urandom_range(0, 2) != 0);
                d  = ($urandom_range(0, 9) == 9) ? 8'($urandom) : pool[$urandom_range(0, 8)];
                e  = ($urandom_range(0, 59) == 0);
                go = ($urandom_range(0, 39) == 0);
                r  = ($urandom_range(0, 499) == 0);
                cyc(v, d, e, go, r);
            end
        end

        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keyboard_decoder.md
Name: keyboard_decoder

Overview:
- Converts the PS/2 set-2 scan-code byte stream from the PS/2 receiver into registered key-held levels (left, right, up, down, jump) and a sticky start_game flag.
- These are exactly the control inputs the player movement FSM consumes.
- Sits between the PS/2 byte receiver and movement.
- Handles make codes, break prefix (F0), extended prefix (E0), typematic repeats, framing errors and stalled sequences.

Parameters:
TIMEOUT_CYCLES, 6_500_000, clk cycles allowed between prefix byte and following byte before the sequence is abandoned (100 ms at 65 MHz); must be >= 2
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of timeout counter (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_data  input  8  received scan-code byte, valid only when rx_valid=1
rx_valid  input  1  single-cycle strobe, one per byte
rx_error  input  1  single-cycle strobe, parity/framing error in receiver
game_over  input  1  level, clears start_game
left  output  1  left arrow held
right  output  1  right arrow held
up  output  1  up arrow held
down  output  1  down arrow held
jump  output  1  space held
start_game  output  1  sticky, set by Enter make

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM ST_IDLE, timeout counter 0. Takes effect immediately; a sequence in progress is discarded.
- Codes:
  - Extended (require E0 prefix): left E0 6B, right E0 74, up E0 75, down E0 72.
  - Plain: space 29 (jump), Enter 5A (start).
  - Prefixes: E0 extended, F0 break.
- FSM states ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK. Transitions occur only on cycles with rx_valid=1, except for timeout and error.
  - ST_IDLE:
    - E0 -> ST_EXT.
    - F0 -> ST_BREAK.
    - 29 -> jump=1.
    - 5A -> start_game=1.
    - Any other byte is ignored. Stay in ST_IDLE.
  - ST_BREAK: any byte -> ST_IDLE. 29 clears jump; 5A has no effect; others ignored.
  - ST_EXT:
    - F0 -> ST_EXT_BREAK.
    - 6B/74/75/72 set the matching output -> ST_IDLE.
    - Other bytes -> ST_IDLE, no output change.
  - ST_EXT_BREAK: 6B/74/75/72 clear the matching output; any byte -> ST_IDLE.
- Plain 6B/74/75/72 without E0 (keypad codes) must not affect arrow outputs.
- Latency: output update is registered, visible on the first rising edge after the cycle carrying rx_valid with the final byte.
- Typematic repeat: a repeated make of a held key leaves the output at 1, with no glitch.
- Simultaneous keys: outputs are independent; left and right may both be 1. Arbitration is movement's job.
- Timeout: the counter runs only in non-IDLE states and clears on every rx_valid.
  - On reaching TIMEOUT_CYCLES-1 with no byte, the FSM returns to ST_IDLE and held outputs are unchanged.
  - A byte arriving in the same cycle as expiry is processed in the current state; the byte wins.
- rx_error: FSM -> ST_IDLE, counter cleared, held outputs unchanged.
  - If rx_valid and rx_error are asserted together, the byte is dropped.
- game_over=1 forces start_game=0 each cycle. It has priority over an Enter make in the same cycle. It does not clear the held-key outputs.
- Unrecognised prefix sequences (e.g. E1 pause) are consumed byte-wise in ST_IDLE as ignored bytes.

Decomposition:
- keyboardPkg gains:
  - scan-code localparams: SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_UP=8'h75, SC_DOWN=8'h72, SC_SPACE=8'h29, SC_ENTER=8'h5A.
  - KBD_STATE_T enum (3 bits reserved for growth).
- Timeout counter stays inline.
- The only natural sub-module is the PS/2 byte receiver, ps2_rx: separate, upstream, not instantiated here.

Test Plan:
- Reset mid-sequence: send E0, assert rst before the next byte, release, send 6B -> left stays 0; the FSM treated 6B as plain and ignored it.
- Extended make/break: E0 6B -> left=1 one cycle after the 6B strobe; E0 F0 6B -> left=0; the right/up/down outputs never toggle.
- Space repeat: 29,29,29 (repeat) -> jump rises once and stays 1 with no low glitch; F0 29 -> jump=0.
- Keypad vs arrow: plain 6B, 74, 75, 72 -> all arrow outputs remain 0.
- Timeout and error:
  - E0 then TIMEOUT_CYCLES idle cycles, then 74 -> right stays 0.
  - E0, rx_error pulse, then F0 29 while jump=1 -> jump=0 (error returned the FSM to ST_IDLE cleanly).
- start_game: 5A -> start_game=1; F0 5A -> still 1; game_over=1 in the same cycle as a 5A strobe -> start_game=0 on the next edge.
